// File: rtl/capture_sequencer.sv
// Logic-analyzer capture controller: pre-trigger fill, armed wait, post-trigger
// fill into a circular sample RAM, then ordered read-out from the oldest sample.
module capture_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  _i_rst,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_trig,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic [DEPTH_LOG2-1:0] i_pretrig,
    input  logic [DIV_W-1:0]      i_div,
    output logic                  o_wr_en,
    output logic [DEPTH_LOG2-1:0] o_wr_addr,
    output logic [WIDTH-1:0]      o_wr_data,
    output logic                  o_rd_en,
    output logic [DEPTH_LOG2-1:0] o_rd_addr,
    output logic                  o_rd_last,
    input  logic                  i_rd_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DEPTH_LOG2-1:0] o_trig_addr
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] ONE      = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE,
        S_READOUT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_p, w_p_nxt;
    logic [DIV_W-1:0]      r_d, w_d_nxt;
    logic [DEPTH_LOG2-1:0] r_r, w_r_nxt;
    logic [DIV_W-1:0]      r_presc, w_presc_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [DEPTH_LOG2-1:0] r_pre_cnt, w_pre_cnt_nxt;
    logic                  r_trig_d;
    logic                  r_pending, w_pending_nxt;
    logic [DEPTH_LOG2-1:0] r_trig_addr, w_trig_addr_nxt;
    logic [DEPTH_LOG2-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [DEPTH_LOG2-1:0] r_rd_cnt, w_rd_cnt_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [WIDTH-1:0]      r_wr_data, w_wr_data_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic                  r_rd_last, w_rd_last_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;

    logic w_capturing;
    logic w_tick;
    logic w_trig_rise;
    logic w_trig_hit;

    assign w_capturing = (r_state == S_PREFILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
    assign w_tick      = w_capturing && (r_presc == '0);
    // An edge seen in the same cycle as a tick is consumed by that tick.
    assign w_trig_rise = i_trig & ~r_trig_d;
    assign w_trig_hit  = r_pending | w_trig_rise;

    // NOTE: every state element is updated with <= so all flops sample the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!_i_rst) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_presc     <= '0;
            r_wr_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_trig_d    <= 1'b0;
            r_pending   <= 1'b0;
            r_trig_addr <= '0;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_d         <= w_d_nxt;
            r_r         <= w_r_nxt;
            r_presc     <= w_presc_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_trig_d    <= i_trig;
            r_pending   <= w_pending_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_last   <= w_rd_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        // NOTE: hold defaults come first so no branch leaves a signal unassigned (no latches).
        w_state_nxt     = r_state;
        w_p_nxt         = r_p;
        w_d_nxt         = r_d;
        w_r_nxt         = r_r;
        w_presc_nxt     = r_presc;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_pre_cnt_nxt   = r_pre_cnt;
        w_pending_nxt   = r_pending;
        w_trig_addr_nxt = r_trig_addr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;

        if (w_capturing) begin
            w_presc_nxt = (r_presc == r_d) ? '0 : r_presc + DIV_W'(1);
        end

        if (w_tick) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_wr_ptr;
            w_wr_data_nxt = i_data;
            w_wr_ptr_nxt  = r_wr_ptr + ONE;
        end

        case (r_state)
            S_IDLE: begin
                w_pending_nxt = 1'b0;
                if (i_arm) begin
                    w_p_nxt       = i_pretrig;
                    w_d_nxt       = i_div;
                    w_wr_ptr_nxt  = '0;
                    w_presc_nxt   = '0;
                    w_pre_cnt_nxt = '0;
                    w_state_nxt   = (i_pretrig == '0) ? S_WAIT_TRIG : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (w_tick) begin
                    w_pre_cnt_nxt = r_pre_cnt + ONE;
                    if ((r_pre_cnt + ONE) == r_p) begin
                        w_state_nxt = S_WAIT_TRIG;
                    end
                end
            end
            S_WAIT_TRIG: begin
                if (w_trig_rise) begin
                    w_pending_nxt = 1'b1;
                end
                if (w_tick && w_trig_hit) begin
                    w_pending_nxt   = 1'b0;
                    w_trig_addr_nxt = r_wr_ptr;
                    w_r_nxt         = LAST_IDX - r_p;
                    w_state_nxt     = (r_p == LAST_IDX) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (w_tick) begin
                    w_r_nxt = r_r - ONE;
                    if (r_r == ONE) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Oldest sample sits P slots before the trigger sample in the ring.
                w_rd_ptr_nxt = r_trig_addr - r_p;
                w_rd_cnt_nxt = '0;
                w_state_nxt  = S_READOUT;
            end
            S_READOUT: begin
                if (i_rd_ready) begin
                    w_rd_ptr_nxt = r_rd_ptr + ONE;
                    w_rd_cnt_nxt = r_rd_cnt + ONE;
                    if (r_rd_cnt == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (i_abort) begin
            w_state_nxt   = S_IDLE;
            w_wr_en_nxt   = 1'b0;
            w_pending_nxt = 1'b0;
        end

        w_rd_en_nxt   = (w_state_nxt == S_READOUT);
        w_rd_last_nxt = w_rd_en_nxt && (w_rd_cnt_nxt == LAST_IDX);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_DONE) || (w_state_nxt == S_READOUT);
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_ptr;
    assign o_rd_last   = r_rd_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_trig_addr = r_trig_addr;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: hand-computed capture timelines with a
// behavioural sample RAM fed from the write port and checked through read-out.
module tb_capture_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_trig;
    logic       i_arm;
    logic       i_abort;
    logic [3:0] i_pretrig;
    logic [15:0] i_div;
    logic       o_wr_en;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_rd_en;
    logic [3:0] o_rd_addr;
    logic       o_rd_last;
    logic       i_rd_ready;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_trig_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram [16];

    capture_sequencer #(.WIDTH(8), .DEPTH_LOG2(4), .DIV_W(16)) dut (
        .i_clk      (clk),
        ._i_rst     (rst_n),
        .i_data     (i_data),
        .i_trig     (i_trig),
        .i_arm      (i_arm),
        .i_abort    (i_abort),
        .i_pretrig  (i_pretrig),
        .i_div      (i_div),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .o_rd_last  (o_rd_last),
        .i_rd_ready (i_rd_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_trig_addr(o_trig_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM as seen by the external memory.
    always @(posedge clk) begin
        if (o_wr_en) ram[o_wr_addr] <= o_wr_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_tests++;
        assert (obs === expd)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    // One clock; inputs change and outputs are sampled 2 time units after the edge.
    task automatic cycle();
        @(posedge clk);
        #2;
        i_data = i_data + 8'd1;
    endtask

    // Arm edge is E0; i_data then reads k-1 at edge Ek.
    task automatic arm(input logic [3:0] p, input logic [15:0] d);
        i_arm     = 1'b1;
        i_pretrig = p;
        i_div     = d;
        cycle();
        i_arm     = 1'b0;
        i_pretrig = 4'd9;
        i_div     = 16'd5;
        i_data    = 8'd0;
    endtask

    task automatic readout(input logic [3:0] start, input logic [7:0] base,
                           input logic [7:0] stride, input bit stall);
        logic [3:0] pat;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        int acc;
        int guard;
        pat   = 4'b1001;
        acc   = 0;
        guard = 0;
        while (acc < 16 && guard < 64) begin
            i_rd_ready = stall ? pat[guard % 4] : 1'b1;
            exp_addr   = start + 4'(acc);
            exp_data   = 8'(int'(base) + int'(stride) * acc);
            check("rd_en", 32'(o_rd_en), 1);
            check("rd_addr", 32'(o_rd_addr), 32'(exp_addr));
            check("rd_last", 32'(o_rd_last), 32'(acc == 15));
            check("rd_data", 32'(ram[o_rd_addr]), 32'(exp_data));
            cycle();
            if (i_rd_ready) acc++;
            guard++;
        end
        check("rd_accepted", 32'(acc), 16);
        i_rd_ready = 1'b0;
        check("rd_end_busy", 32'(o_busy), 0);
        check("rd_end_en", 32'(o_rd_en), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        i_data     = 8'd0;
        i_trig     = 1'b0;
        i_arm      = 1'b0;
        i_abort    = 1'b0;
        i_pretrig  = 4'd0;
        i_div      = 16'd0;
        i_rd_ready = 1'b0;
        repeat (3) cycle();

        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_wr_addr", 32'(o_wr_addr), 0);
        check("rst_wr_data", 32'(o_wr_data), 0);
        check("rst_rd_en", 32'(o_rd_en), 0);
        check("rst_rd_addr", 32'(o_rd_addr), 0);
        check("rst_rd_last", 32'(o_rd_last), 0);
        check("rst_trig_addr", 32'(o_trig_addr), 0);
        rst_n = 1'b1;
        cycle();
        check("idle_busy", 32'(o_busy), 0);

        // A: P=4, D=0, trigger edge consumed at E21 (value 20, address 4).
        arm(4'd4, 16'd0);
        check("A_busy", 32'(o_busy), 1);
        check("A_wr_en_pre", 32'(o_wr_en), 0);
        cycle();
        check("A_wr_en", 32'(o_wr_en), 1);
        check("A_wr_addr0", 32'(o_wr_addr), 0);
        check("A_wr_data0", 32'(o_wr_data), 0);
        repeat (19) cycle();
        i_trig = 1'b1;
        cycle();
        check("A_trig_addr", 32'(o_trig_addr), 4);
        check("A_trig_wr_addr", 32'(o_wr_addr), 4);
        check("A_trig_wr_data", 32'(o_wr_data), 20);
        check("A_not_done", 32'(o_done), 0);
        repeat (11) cycle();
        check("A_done", 32'(o_done), 1);
        check("A_last_wr_addr", 32'(o_wr_addr), 15);
        check("A_last_wr_data", 32'(o_wr_data), 31);
        cycle();
        i_trig = 1'b0;
        readout(4'd0, 8'd16, 8'd1, 1'b0);

        // B: P=2, D=2, ticks at E1,E4,E7,E10; pulse at E8 latched, consumed at E10.
        arm(4'd2, 16'd2);
        cycle();
        check("B_wr_en_t0", 32'(o_wr_en), 1);
        check("B_wr_data_t0", 32'(o_wr_data), 0);
        cycle();
        check("B_wr_en_gap", 32'(o_wr_en), 0);
        repeat (2) cycle();
        check("B_wr_en_t1", 32'(o_wr_en), 1);
        check("B_wr_addr_t1", 32'(o_wr_addr), 1);
        check("B_wr_data_t1", 32'(o_wr_data), 3);
        repeat (3) cycle();
        i_trig = 1'b1;
        cycle();
        i_trig = 1'b0;
        check("B_pulse_no_wr", 32'(o_wr_en), 0);
        repeat (2) cycle();
        check("B_trig_addr", 32'(o_trig_addr), 3);
        check("B_trig_wr_data", 32'(o_wr_data), 9);
        repeat (38) cycle();
        check("B_not_done", 32'(o_done), 0);
        cycle();
        check("B_done", 32'(o_done), 1);
        cycle();
        readout(4'd1, 8'd3, 8'd3, 1'b0);

        // C: P=0, trigger on the first cycle after arm -> trigger at address 0.
        arm(4'd0, 16'd0);
        i_trig = 1'b1;
        cycle();
        check("C_trig_addr", 32'(o_trig_addr), 0);
        check("C_trig_wr_addr", 32'(o_wr_addr), 0);
        check("C_trig_wr_data", 32'(o_wr_data), 0);
        repeat (15) cycle();
        check("C_done", 32'(o_done), 1);
        cycle();
        i_trig = 1'b0;
        readout(4'd0, 8'd0, 8'd1, 1'b0);

        // P=15: trigger write goes straight to DONE.
        arm(4'd15, 16'd0);
        repeat (15) cycle();
        check("P15_busy", 32'(o_busy), 1);
        check("P15_not_done", 32'(o_done), 0);
        i_trig = 1'b1;
        cycle();
        check("P15_trig_addr", 32'(o_trig_addr), 15);
        check("P15_trig_wr_data", 32'(o_wr_data), 15);
        check("P15_done", 32'(o_done), 1);
        cycle();
        i_trig = 1'b0;
        readout(4'd0, 8'd0, 8'd1, 1'b0);

        // D: edge during PREFILL held high is ignored; fall-then-rise triggers.
        arm(4'd4, 16'd0);
        cycle();
        i_trig = 1'b1;
        repeat (9) cycle();
        check("D_no_done", 32'(o_done), 0);
        check("D_busy", 32'(o_busy), 1);
        check("D_trig_addr_held", 32'(o_trig_addr), 15);
        i_trig = 1'b0;
        cycle();
        i_trig = 1'b1;
        cycle();
        check("D_trig_addr", 32'(o_trig_addr), 11);
        check("D_trig_wr_addr", 32'(o_wr_addr), 11);
        check("D_trig_wr_data", 32'(o_wr_data), 11);
        repeat (11) cycle();
        check("D_done", 32'(o_done), 1);
        cycle();
        i_trig = 1'b0;
        readout(4'd7, 8'd7, 8'd1, 1'b1);

        // E: abort mid-POST, arm+abort in IDLE, abort mid-READOUT.
        cycle();
        arm(4'd4, 16'd0);
        repeat (5) cycle();
        i_trig = 1'b1;
        cycle();
        check("E_trig_addr", 32'(o_trig_addr), 5);
        repeat (3) cycle();
        i_abort = 1'b1;
        cycle();
        check("E_post_abort_busy", 32'(o_busy), 0);
        check("E_post_abort_wr_en", 32'(o_wr_en), 0);
        check("E_post_abort_done", 32'(o_done), 0);
        i_abort = 1'b0;
        i_trig  = 1'b0;
        i_arm   = 1'b1;
        i_abort = 1'b1;
        cycle();
        check("E_arm_abort_idle", 32'(o_busy), 0);
        i_arm   = 1'b0;
        i_abort = 1'b0;
        arm(4'd0, 16'd0);
        i_trig = 1'b1;
        cycle();
        check("E_rearm_trig_addr", 32'(o_trig_addr), 0);
        check("E_rearm_wr_data", 32'(o_wr_data), 0);
        repeat (15) cycle();
        check("E_rearm_done", 32'(o_done), 1);
        cycle();
        check("E_rd_en", 32'(o_rd_en), 1);
        check("E_rd_addr0", 32'(o_rd_addr), 0);
        i_rd_ready = 1'b1;
        repeat (3) cycle();
        check("E_rd_addr3", 32'(o_rd_addr), 3);
        i_abort = 1'b1;
        cycle();
        check("E_rd_abort_en", 32'(o_rd_en), 0);
        check("E_rd_abort_busy", 32'(o_busy), 0);
        check("E_rd_abort_done", 32'(o_done), 0);
        i_abort    = 1'b0;
        i_rd_ready = 1'b0;
        i_trig     = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
